// File: rtl/grant_sequencer.sv
// Sequential wrapper around the 8-client priority arbiter: sticky request capture,
// grant capture, fixed-length burst service on a valid/ready beat port, completion pulse.
module grant_sequencer #(
    parameter int BURST_LEN = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] req,
    output logic [7:0] pending,
    input  logic [7:0] grant,
    output logic [2:0] owner,
    output logic       busy,
    output logic       beat_valid,
    input  logic       beat_ready,
    output logic       beat_last,
    output logic [7:0] done,
    output logic       grant_err
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE,
        RELEASE
    } state_t;

    localparam logic [7:0] LAST_CNT    = 8'(BURST_LEN - 1);
    localparam logic       SINGLE_BEAT = (BURST_LEN == 1);

    state_t     state;
    logic [7:0] cnt;
    logic [7:0] cnt_next;
    logic [7:0] owner_onehot;
    logic [7:0] clr;

    function automatic logic [2:0] lowest_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic multi_hot(input logic [7:0] v);
        return (v & (v - 8'd1)) != 8'd0;
    endfunction

    assign cnt_next     = cnt + 8'd1;
    assign owner_onehot = 8'b1 << owner;
    assign clr          = (state == RELEASE) ? owner_onehot : 8'h00;

    // Sticky request vector: a new strobe on the served bit survives its own release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 8'h00;
        end else begin
            pending <= (pending & ~clr) | req;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            owner      <= 3'd0;
            cnt        <= 8'd0;
            busy       <= 1'b0;
            beat_valid <= 1'b0;
            beat_last  <= 1'b0;
            done       <= 8'h00;
            grant_err  <= 1'b0;
        end else begin
            done      <= 8'h00;
            grant_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant != 8'h00) begin
                        owner      <= lowest_idx(grant);
                        cnt        <= 8'd0;
                        state      <= SERVE;
                        busy       <= 1'b1;
                        beat_valid <= 1'b1;
                        beat_last  <= SINGLE_BEAT;
                        grant_err  <= multi_hot(grant);
                    end
                end
                SERVE: begin
                    // Grant is ignored here, so a lower-index request waits for the next IDLE.
                    if (beat_ready) begin
                        cnt <= cnt_next;
                        if (beat_last) begin
                            state      <= RELEASE;
                            beat_valid <= 1'b0;
                            beat_last  <= 1'b0;
                            done       <= owner_onehot;
                        end else begin
                            beat_last <= (cnt_next == LAST_CNT);
                        end
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    beat_valid <= 1'b0;
                    beat_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/grant_sequencer.md
# grant_sequencer

Sequential front/back end for the team's 8-client combinational priority arbiter (lowest index wins, one-hot grant). Latches client requests into a sticky pending vector that feeds the arbiter, captures the returned one-hot grant, and serves the winner for a fixed-length burst on a valid/ready beat interface. Clears the served request and reports completion. Sits between the eight requesting clients and the shared resource, with the arbiter in the loop.

## Interface
- BURST_LEN, 4: beats per grant; legal range 1..255; counter is 8 bits.

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- req  in  8  request strobes; bit i = 1 in any cycle sets pending[i]
- pending  out  8  registered sticky request vector; drives arbiter input
- grant  in  8  one-hot grant from arbiter; combinational function of pending
- owner  out  3  binary index of client being served
- busy  out  1  high in SERVE and RELEASE
- beat_valid  out  1  beat offered to shared resource
- beat_ready  in  1  resource accepts beat
- beat_last  out  1  current beat is the final beat of the burst
- done  out  8  one-cycle one-hot pulse, served client's bit
- grant_err  out  1  one-cycle pulse: captured grant was not one-hot

## Operation
- Reset, asynchronous on reset_n low: state IDLE; pending, owner, beat count, busy, beat_valid, beat_last, done, grant_err all 0. Reset mid-burst aborts immediately; no done pulse.
- Pending update every cycle: pending <= (pending & ~clr) | req. clr = owner one-hot in RELEASE, else 0. Set wins over clear on the same bit.
- IDLE: if grant != 0, capture owner = index of lowest set grant bit, clear beat count, go to SERVE. If grant has more than one bit set, also pulse grant_err in the next cycle. grant == 0 stays in IDLE.
- SERVE:
  - beat_valid = 1.
  - A beat transfers on beat_valid & beat_ready; the count increments on each transfer.
  - beat_last = 1 while count == BURST_LEN-1.
  - A transfer with beat_last goes to RELEASE.
  - beat_valid never drops before a transfer.
  - grant is ignored; owner is held.
- RELEASE, one cycle: done = one-hot(owner); pending[owner] is cleared, subject to set-wins; beat_valid = 0. Next state IDLE.
- Outputs are Moore outputs of registered state and registered owner/count. Only the pending-to-grant path is combinational, and it lies outside this block.
- BURST_LEN = 1: beat_last is high for the whole SERVE state.

## Timing
- Request to first beat: req high in cycle 0, pending visible in cycle 1, grant captured at the end of cycle 1, beat_valid from cycle 2.
- With beat_ready held high, a burst occupies cycles 2 .. BURST_LEN+1. RELEASE/done is at cycle BURST_LEN+2; IDLE is at BURST_LEN+3.
- Back-to-back service costs BURST_LEN+2 cycles per grant: SERVE, RELEASE, plus one IDLE cycle to sample the grant.
- Each cycle with beat_ready low in SERVE extends the burst by exactly one cycle.
- A new lower-index request during SERVE does not preempt the current burst. It wins at the next IDLE.

## Test plan
- Reset: assert reset_n = 0 mid-simulation with state SERVE and count 2. All outputs are 0 within the same cycle, with no done pulse. After release the block returns to IDLE with pending = 0x00.
- Single request, BURST_LEN = 4, beat_ready = 1, arbiter in loop: req = 0x04 for cycle 0 only gives:
  - pending = 0x04 at cycle 1;
  - owner = 2 and beat_valid high over cycles 2-5;
  - beat_last at cycle 5;
  - done = 0x04 at cycle 6;
  - pending = 0x00 at cycle 7.
- Priority/ordering: req = 0x81 at cycle 0 serves client 0 first. Expect done = 0x01 at cycle 6 and done = 0x80 at cycle 12, owner = 7 during cycles 8-11.
- Backpressure: single request with beat_ready = 0 in cycles 3-5. beat_valid stays high and the count holds at 1. beat_last lands at cycle 8 and done = 0x04 at cycle 9.
- Set-wins: req = 0x04 asserted again in the RELEASE cycle. pending[2] stays 1 and client 2 is re-served, with a second done = 0x04 exactly 6 cycles after the first.
- Illegal grant, arbiter bypassed: drive grant = 0x06 in IDLE. Expect owner = 1, grant_err pulse for one cycle, and a normal burst ending with done = 0x02.
